dp_proc_multi: RTL and testbench

Parametrised successor of the single-accumulator capture/add/sub datapath. It holds NUM_ACC accumulators and applies add, subtract, load, clear and iterative multiply operations to a selected accumulator. A valid/ready handshake stalls the producer during multi-cycle multiplies. Each result is reported on a one-cycle output strobe with per-accumulator sticky overflow flags; the block sits between the operand-capture logic and the result display/readback path.

---
 rtl/dp_proc_multi_if.sv | 26 ++
 rtl/dp_proc_multi.sv | 177 +++++++++++++++++
 tb/tb_dp_proc_multi.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_proc_multi_if.sv
// dp_proc_multi_if: request/result handshake bundle for dp_proc_multi.
// master = producer/consumer side, slave = datapath side.
interface dp_proc_multi_if #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 5,
  parameter int SEL_W  = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] d_in;
  logic              out_valid;
  logic [SEL_W-1:0]  out_sel;
  logic [ACC_W-1:0]  result;

  modport master (
    output in_valid, op, sel, d_in,
    input  in_ready, out_valid, out_sel, result
  );

  modport slave (
    input  in_valid, op, sel, d_in,
    output in_ready, out_valid, out_sel, result
  );
endinterface

// File: rtl/dp_proc_multi.sv
// dp_proc_multi: NUM_ACC accumulators with add/sub/load/clr/iterative mul.
// Define DP_PROC_SAT_EN for saturating arithmetic instead of wrap-around.
module dp_proc_multi #(
  parameter int DATA_W  = 4,
  parameter int ACC_W   = 5,
  parameter int NUM_ACC = 4,
  parameter int SEL_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               clear_all,
  dp_proc_multi_if.slave     bus,
  output logic               busy,
  output logic [NUM_ACC-1:0] ovf,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [ACC_W-1:0]   rd_data
);

  localparam int PROD_W = ACC_W + DATA_W;
  localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);
  localparam logic [SEL_W:0]   N_ACC = (SEL_W+1)'(NUM_ACC);
`ifdef DP_PROC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e                        state_q, state_d;
  logic [NUM_ACC-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [NUM_ACC-1:0]            ovf_q, ovf_d;
  logic [ACC_W-1:0]              mcand_q, mcand_d;
  logic [DATA_W-1:0]             mplr_q, mplr_d;
  logic [SEL_W-1:0]              tgt_q, tgt_d;
  logic [PROD_W-1:0]             prod_q, prod_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          out_valid_q, out_valid_d;
  logic [SEL_W-1:0]              out_sel_q, out_sel_d;
  logic [ACC_W-1:0]              result_q, result_d;

  logic              in_range;
  logic [ACC_W-1:0]  cur;
  logic [ACC_W-1:0]  d_ext;
  logic [ACC_W:0]    sum;
  logic              borrow;
  logic [PROD_W-1:0] prod_nx;
  logic              hi;
  logic [ACC_W-1:0]  val;
  logic              is_add, is_sub, is_ld, is_clr, is_mul;

  assign is_add = (bus.op == 3'b000);
  assign is_sub = (bus.op == 3'b001);
  assign is_ld  = (bus.op == 3'b010);
  assign is_clr = (bus.op == 3'b011);
  assign is_mul = (bus.op == 3'b100);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    tgt_d       = tgt_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_sel_d   = out_sel_q;
    result_d    = result_q;
    in_range    = ({1'b0, bus.sel} < N_ACC);
    cur         = in_range ? acc_q[bus.sel] : '0;
    d_ext       = ACC_W'(bus.d_in);
    sum         = {1'b0, cur} + (ACC_W+1)'(bus.d_in);
    borrow      = (d_ext > cur);
    prod_nx     = prod_q;
    hi          = 1'b0;
    val         = cur;

    if (clear_all) begin
      state_d = S_IDLE;
      acc_d   = '0;
      ovf_d   = '0;
    end else if (state_q == S_MUL) begin
      // one shift-add step per edge, LSB of multiplier first
      if (mplr_q[cnt_q])
        prod_nx = prod_q + (PROD_W'(mcand_q) << cnt_q);
      prod_d = prod_nx;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        hi  = |prod_nx[PROD_W-1:ACC_W];
        val = (SAT && hi) ? '1 : prod_nx[ACC_W-1:0];
        acc_d[tgt_q] = val;
        if (hi)
          ovf_d[tgt_q] = 1'b1;
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
        out_sel_d   = tgt_q;
        result_d    = val;
      end
    end else if (bus.in_valid) begin
      out_valid_d = 1'b1;
      out_sel_d   = bus.sel;
      if (in_range) begin
        unique case (1'b1)
          is_add: begin
            val = (SAT && sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
            if (sum[ACC_W])
              ovf_d[bus.sel] = 1'b1;
          end
          is_sub: begin
            val = (SAT && borrow) ? '0 : cur - d_ext;
            if (borrow)
              ovf_d[bus.sel] = 1'b1;
          end
          is_ld: begin
            val = d_ext;
            ovf_d[bus.sel] = 1'b0;
          end
          is_clr: begin
            val = '0;
            ovf_d[bus.sel] = 1'b0;
          end
          is_mul: begin
            state_d     = S_MUL;
            mcand_d     = cur;
            mplr_d      = bus.d_in;
            tgt_d       = bus.sel;
            prod_d      = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
          end
          default: ;
        endcase
        acc_d[bus.sel] = val;
      end
      result_d = val;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      ovf_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      tgt_q       <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      tgt_q       <= tgt_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      result_q    <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.result    = result_q;
  assign busy          = (state_q == S_MUL);
  assign ovf           = ovf_q;
  assign rd_data = ({1'b0, rd_sel} < N_ACC) ? acc_q[rd_sel] : '0;

endmodule

// File: tb/tb_dp_proc_multi.sv
// tb_dp_proc_multi: directed stimulus against an arithmetic accumulator model.
// Honours DP_PROC_SAT_EN for the expected saturating results.
module tb_dp_proc_multi;
  localparam int DATA_W  = 4;
  localparam int ACC_W   = 5;
  localparam int NUM_ACC = 4;
  localparam int SEL_W   = 2;
  localparam int MAXV    = (1 << ACC_W) - 1;
`ifdef DP_PROC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               rst = 1'b1;
  logic               clear_all = 1'b0;
  logic [SEL_W-1:0]   rd_sel = '0;
  logic               busy;
  logic [NUM_ACC-1:0] ovf;
  logic [ACC_W-1:0]   rd_data;

  dp_proc_multi_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SEL_W(SEL_W)) bus ();

  dp_proc_multi #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_ACC(NUM_ACC), .SEL_W(SEL_W)
  ) dut (
    .clock(clock), .rst(rst), .clear_all(clear_all), .bus(bus),
    .busy(busy), .ovf(ovf), .rd_sel(rd_sel), .rd_data(rd_data)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  logic [ACC_W-1:0] last_res = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: accumulators as plain integers, mul as a countdown of DATA_W edges
  int acc_m[NUM_ACC];
  bit [NUM_ACC-1:0] ovf_m = '0;
  int mul_left = 0;
  int mul_tgt = 0;
  int mul_p = 0;
  bit exp_ov = 0;
  int exp_sel = 0;
  int exp_res = 0;
  bit started = 0;

  always @(posedge clock) begin
    int v, s, d;
    started = 1;
    exp_ov = 0;
    if (rst || clear_all) begin
      foreach (acc_m[i]) acc_m[i] = 0;
      ovf_m = '0;
      mul_left = 0;
      if (rst) begin
        exp_sel = 0;
        exp_res = 0;
      end
    end else if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) begin
        v = mul_p;
        if (v > MAXV) begin
          ovf_m[mul_tgt] = 1'b1;
          v = SAT ? MAXV : v % (MAXV + 1);
        end
        acc_m[mul_tgt] = v;
        exp_ov = 1;
        exp_sel = mul_tgt;
        exp_res = v;
      end
    end else if (bus.in_valid) begin
      s = int'(bus.sel);
      d = int'(bus.d_in);
      v = acc_m[s];
      exp_ov = 1;
      exp_sel = s;
      case (bus.op)
        3'd0: begin
          v = v + d;
          if (v > MAXV) begin
            ovf_m[s] = 1'b1;
            v = SAT ? MAXV : v - (MAXV + 1);
          end
        end
        3'd1: begin
          v = v - d;
          if (v < 0) begin
            ovf_m[s] = 1'b1;
            v = SAT ? 0 : v + MAXV + 1;
          end
        end
        3'd2: begin v = d; ovf_m[s] = 1'b0; end
        3'd3: begin v = 0; ovf_m[s] = 1'b0; end
        3'd4: begin
          mul_left = DATA_W;
          mul_tgt = s;
          mul_p = acc_m[s] * d;
          exp_ov = 0;
        end
        default: ;
      endcase
      acc_m[s] = v;
      exp_res = v;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (bus.out_valid === 1'b1) begin
        n_out++;
        last_res = bus.result;
      end
      if (exp_ov) begin
        chk("out_sel", 32'(bus.out_sel), exp_sel);
        chk("result", 32'(bus.result), exp_res);
      end
      chk("in_ready", 32'(bus.in_ready), 32'(mul_left == 0));
      chk("busy", 32'(busy), 32'(mul_left != 0));
      chk("ovf", 32'(ovf), 32'(ovf_m));
      chk("rd_data", 32'(rd_data), acc_m[rd_sel]);
    end
  end

  task automatic issue(input int o, input int s, input int d,
                       output int stalls);
    bit rdy;
    rdy = 0;
    bus.in_valid = 1'b1;
    bus.op = 3'(o);
    bus.sel = SEL_W'(s);
    bus.d_in = DATA_W'(d);
    stalls = 0;
    for (int i = 0; i < 50; i++) begin
      rdy = bus.in_ready;
      @(posedge clock);
      #1;
      if (rdy) break;
      stalls++;
    end
    chk("accept", 32'(rdy), 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n0, input int n, output int lat);
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      if (n_out >= n0 + n) break;
      @(negedge clock);
      #1;
      lat++;
    end
    chk("out_timeout", 32'(n_out >= n0 + n), 1);
  endtask

  task automatic do_op(input string nm, input int o, input int s,
                       input int d, input int exp_lit, output int lat);
    int n0, st;
    n0 = n_out;
    issue(o, s, d, st);
    wait_outs(n0, 1, lat);
    chk(nm, 32'(last_res), exp_lit);
  endtask

  task automatic abort_mul(input bit use_rst, input int s);
    int n0, st;
    n0 = n_out;
    issue(4, s, 3, st);
    chk("abort_busy", 32'(busy), 1);
    repeat (2) @(posedge clock);
    #1;
    if (use_rst) rst = 1'b1;
    else clear_all = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    clear_all = 1'b0;
    chk("abort_ready", 32'(bus.in_ready), 1);
    chk("abort_ovf", 32'(ovf), 0);
    for (int i = 0; i < NUM_ACC; i++) begin
      rd_sel = SEL_W'(i);
      #1;
      chk("abort_rd", 32'(rd_data), 0);
    end
    repeat (8) @(posedge clock);
    #1;
    chk("abort_no_out", n_out - n0, 0);
  endtask

  initial begin
    int lat, st, n0;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.sel = '0;
    bus.d_in = '0;
    repeat (3) @(posedge clock);
    #1;
    rst = 1'b0;
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_rd", 32'(rd_data), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);

    do_op("t1_add_a", 0, 0, 9, 9, lat);
    chk("t1_lat", lat, 1);
    do_op("t1_add_b", 0, 0, 9, 18, lat);
    chk("t1_ovf", 32'(ovf), 0);
    rd_sel = 0;
    #1;
    chk("t1_rd", 32'(rd_data), 18);
    chk("t1_model", acc_m[0], 18);

    do_op("t2_ld", 2, 1, 15, 15, lat);
    do_op("t2_add_a", 0, 1, 15, 30, lat);
    do_op("t2_add_b", 0, 1, 15, SAT ? 31 : 13, lat);
    chk("t2_ovf1", 32'(ovf[1]), 1);

    do_op("t3_ld", 2, 2, 3, 3, lat);
    do_op("t3_sub", 1, 2, 5, SAT ? 0 : 30, lat);
    chk("t3_ovf2", 32'(ovf[2]), 1);
    do_op("t3_clr", 3, 2, 0, 0, lat);
    chk("t3_ovf2_clr", 32'(ovf[2]), 0);

    do_op("t4_ld", 2, 3, 6, 6, lat);
    n0 = n_out;
    issue(4, 3, 5, st);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_ready", 32'(bus.in_ready), 0);
    wait_outs(n0, 1, lat);
    chk("t4_mul_a", 32'(last_res), 30);
    chk("t4_lat", lat, DATA_W + 1);
    chk("t4_ovf3", 32'(ovf[3]), 0);
    do_op("t4_mul_b", 4, 3, 3, SAT ? 31 : 26, lat);
    chk("t4_ovf3_set", 32'(ovf[3]), 1);
    chk("t4_model", acc_m[3], SAT ? 31 : 26);

    n0 = n_out;
    issue(4, 1, 2, st);
    issue(0, 0, 1, st);
    chk("t5_stalls", st, DATA_W);
    wait_outs(n0, 2, lat);
    repeat (5) @(posedge clock);
    #1;
    chk("t5_outs", n_out - n0, 2);
    chk("t5_last", 32'(last_res), 19);
    rd_sel = 1;
    #1;
    chk("t5_rd1", 32'(rd_data), SAT ? 31 : 26);
    rd_sel = 0;
    #1;
    chk("t5_rd0", 32'(rd_data), 19);

    do_op("t6_ld", 2, 2, 5, 5, lat);
    abort_mul(1'b0, 2);
    do_op("t6_ld_b", 2, 3, 7, 7, lat);
    abort_mul(1'b1, 3);
    do_op("t6_recover", 0, 3, 4, 4, lat);

    repeat (2) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
